// File: rtl/i2s_pkg.sv
// Shared I2S definitions: sample/slot geometry and
// channel-state encodings common to transmitter and receiver.
package i2s_pkg;

  localparam int I2S_WIDTH = 24;
  localparam int I2S_SLOT  = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } i2s_state_t;

endpackage

// File: rtl/edge_det.sv
// Registers a clock-domain-synchronous input and reports
// rise/fall/change pulses relative to its previous value.
module edge_det (
  input  logic mck,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall,
  output logic chg
);

  always_ff @(posedge mck or negedge reset) begin
    if (!reset) q <= 1'b0;
    else        q <= d;
  end

  assign rise = d & ~q;
  assign fall = q & ~d;
  assign chg  = d ^ q;

endmodule

// File: rtl/i2s_xmit.sv
// I2S transmitter: double-buffered stereo pair, shifted out
// MSB first one bck after each lrck edge, on the mck domain.
module i2s_xmit
  import i2s_pkg::*;
#(
  parameter int WIDTH = I2S_WIDTH,
  parameter int SLOT  = I2S_SLOT
) (
  input  logic             mck,
  input  logic             reset,
  input  logic             bck,
  input  logic             lrck,
  input  logic [WIDTH-1:0] in_left,
  input  logic [WIDTH-1:0] in_right,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             sdout,
  output logic             underrun
);

  localparam logic [4:0] BIT_MAX = 5'(SLOT - 1);
  localparam logic [4:0] BIT_LSB = 5'(WIDTH);

  logic bck_q, bck_rise, bck_fall, bck_chg;
  logic lrck_q, lrck_rise, lrck_fall, lrck_chg;

  edge_det u_bck (
    .mck  (mck),
    .reset(reset),
    .d    (bck),
    .q    (bck_q),
    .rise (bck_rise),
    .fall (bck_fall),
    .chg  (bck_chg)
  );

  edge_det u_lrck (
    .mck  (mck),
    .reset(reset),
    .d    (lrck),
    .q    (lrck_q),
    .rise (lrck_rise),
    .fall (lrck_fall),
    .chg  (lrck_chg)
  );

  logic unused_edges;
  assign unused_edges = ^{bck_q, bck_rise, bck_chg, lrck_q};

  i2s_state_t state, state_nxt;

  logic             lr_chg, frame_start, to_right;
  logic             accept, hold_full;
  logic [WIDTH-1:0] hold_l, hold_r, act_l, act_r;
  logic [WIDTH-1:0] cur, shifted;
  logic [4:0]       bitn, bitn_inc;
  logic             sd_bit;

  assign lr_chg      = bck_fall & lrck_chg;
  assign frame_start = bck_fall & lrck_fall;
  assign to_right    = bck_fall & lrck_rise & (state != IDLE);

  assign in_ready = ~hold_full;
  assign accept   = in_valid & in_ready;
  assign underrun = frame_start & ~hold_full;

  // Any slot edge re-forces the state, so a divider glitch resyncs.
  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      frame_start: state_nxt = LEFT;
      to_right:    state_nxt = RIGHT;
      default:     state_nxt = state;
    endcase
  end

  always_ff @(posedge mck or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    bitn_inc = (bitn == BIT_MAX) ? bitn : bitn + 5'd1;
    cur      = (state == RIGHT) ? act_r : act_l;
    shifted  = cur << (bitn_inc - 5'd1);
    sd_bit   = (state != IDLE) && (bitn_inc <= BIT_LSB)
               && shifted[WIDTH-1];
  end

  always_ff @(posedge mck or negedge reset) begin
    if (!reset) begin
      hold_full <= 1'b0;
      hold_l    <= '0;
      hold_r    <= '0;
      act_l     <= '0;
      act_r     <= '0;
      bitn      <= '0;
      sdout     <= 1'b0;
    end else begin
      if (accept) begin
        hold_l <= in_left;
        hold_r <= in_right;
      end
      // No bypass: a pair arriving on the frame-start cycle waits.
      if (frame_start) begin
        act_l <= hold_full ? hold_l : '0;
        act_r <= hold_full ? hold_r : '0;
      end
      if (accept)           hold_full <= 1'b1;
      else if (frame_start) hold_full <= 1'b0;
      if (lr_chg) begin
        bitn  <= '0;
        sdout <= 1'b0;
      end else if (bck_fall) begin
        bitn  <= bitn_inc;
        sdout <= sd_bit;
      end
    end
  end

endmodule

// File: tb/tb_i2s_xmit.sv
// Directed bench for i2s_xmit with an mck/16 bit clock
// and 64-bck frame generated in the bench.
module tb_i2s_xmit;

  logic        mck = 1'b0;
  logic        reset;
  logic        bck, lrck;
  logic [23:0] in_left, in_right;
  logic        in_valid, in_ready, sdout, underrun;

  always #5 mck = ~mck;

  i2s_xmit #(.WIDTH(24), .SLOT(32)) dut (
    .mck     (mck),
    .reset   (reset),
    .bck     (bck),
    .lrck    (lrck),
    .in_left (in_left),
    .in_right(in_right),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .sdout   (sdout),
    .underrun(underrun)
  );

  int n_run = 0;
  int n_fail = 0;
  int q = 300;
  int bad_edges = 0;
  int ur, hi;
  logic s_sd, s_rdy, s_ur, sd_prev;
  logic [31:0] lw, rw;
  logic [23:0] pl[$];
  logic [23:0] pr[$];

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] slot_word(logic [23:0] s);
    return {1'b0, s, 7'b0};
  endfunction

  task automatic drive();
    bck      = q[3];
    lrck     = q[9];
    in_valid = (pl.size() > 0);
    in_left  = in_valid ? pl[0] : 24'h0;
    in_right = in_valid ? pr[0] : 24'h0;
  endtask

  task automatic sample();
    s_sd  = sdout;
    s_rdy = in_ready;
    s_ur  = underrun;
    if (s_sd !== sd_prev && q[3:0] != 4'd1) bad_edges++;
    sd_prev = s_sd;
  endtask

  task automatic step();
    logic acc;
    acc = in_valid & in_ready & reset;
    @(posedge mck);
    if (acc) begin
      void'(pl.pop_front());
      void'(pr.pop_front());
    end
    #1;
    q = (q + 1) % 1024;
    drive();
    #1;
    sample();
  endtask

  task automatic push(logic [23:0] l, logic [23:0] r);
    pl.push_back(l);
    pr.push_back(r);
    drive();
  endtask

  task automatic wait_q(int v, output int nu, output int nh);
    nu = 0;
    nh = 0;
    for (int i = 0; i < 1100; i++) begin
      if (q == v) return;
      nu += s_ur ? 1 : 0;
      nh += s_sd ? 1 : 0;
      step();
    end
    check("wait_q", q, v);
  endtask

  task automatic run_frame(output logic [31:0] l,
                           output logic [31:0] r,
                           output int nu);
    int j;
    l  = '0;
    r  = '0;
    nu = 0;
    for (int i = 0; i < 1024; i++) begin
      nu += s_ur ? 1 : 0;
      if (q[3:0] == 4'd1) begin
        j = q[8:4];
        if (q[9]) r[31-j] = s_sd;
        else      l[31-j] = s_sd;
      end
      step();
    end
  endtask

  initial begin
    reset   = 1'b0;
    sd_prev = 1'b0;
    drive();
    #2;
    sample();
    check("rst_sd", s_sd, 0);
    check("rst_rdy", s_rdy, 1);
    check("rst_ur", s_ur, 0);
    repeat (4) step();
    reset = 1'b1;

    wait_q(0, ur, hi);
    check("idle_ur", ur, 0);
    check("idle_sd", hi, 0);
    for (int f = 0; f < 2; f++) begin
      run_frame(lw, rw, ur);
      check("empty_ur", ur, 1);
      check("empty_l", lw, 0);
      check("empty_r", rw, 0);
      check("empty_rdy", s_rdy, 1);
    end

    wait_q(768, ur, hi);
    push(24'hA5F00F, 24'h800001);
    step();
    check("rdy_fall", s_rdy, 0);
    wait_q(0, ur, hi);
    run_frame(lw, rw, ur);
    check("a5_l", lw, 32'h52F80780);
    check("a5_r", rw, 32'h40000080);
    check("a5_ur", ur, 0);

    wait_q(512, ur, hi);
    push(24'h123456, 24'h654321);
    push(24'h7FFFFF, 24'h000001);
    wait_q(900, ur, hi);
    check("b2b_rdy", s_rdy, 0);
    check("b2b_pend", pl.size(), 1);
    wait_q(0, ur, hi);
    run_frame(lw, rw, ur);
    check("p1_l", lw, slot_word(24'h123456));
    check("p1_r", rw, slot_word(24'h654321));
    check("p1_ur", ur, 0);
    check("p2_acc", pl.size(), 0);
    run_frame(lw, rw, ur);
    check("p2_l", lw, slot_word(24'h7FFFFF));
    check("p2_r", rw, slot_word(24'h000001));
    check("p2_ur", ur, 0);

    check("fs_ur", s_ur, 1);
    push(24'h000001, 24'hFFFFFF);
    run_frame(lw, rw, ur);
    check("fs_ur_cnt", ur, 1);
    check("fs_l", lw, 0);
    check("fs_r", rw, 0);
    push(24'hFFFFFF, 24'h000000);
    run_frame(lw, rw, ur);
    check("p4_l", lw, slot_word(24'h000001));
    check("p4_r", rw, slot_word(24'hFFFFFF));
    check("p4_ur", ur, 0);

    push(24'h123123, 24'h321321);
    wait_q(200, ur, hi);
    check("pre_rst_sd", s_sd, 1);
    check("pre_rst_rdy", s_rdy, 0);
    check("p5b_acc", pl.size(), 0);
    reset   = 1'b0;
    sd_prev = 1'b0;
    #1;
    check("mid_rst_sd", sdout, 0);
    check("mid_rst_rdy", in_ready, 1);
    check("mid_rst_ur", underrun, 0);
    repeat (3) step();
    reset = 1'b1;

    wait_q(700, ur, hi);
    push(24'h5A5A5A, 24'h0F0F0F);
    wait_q(0, ur, hi);
    check("resync_idle_sd", hi, 0);
    run_frame(lw, rw, ur);
    check("p6_l", lw, slot_word(24'h5A5A5A));
    check("p6_r", rw, slot_word(24'h0F0F0F));
    check("p6_ur", ur, 0);
    run_frame(lw, rw, ur);
    check("drop_ur", ur, 1);
    check("drop_l", lw, 0);
    check("drop_r", rw, 0);

    check("sd_timing", bad_edges, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
